operand_fetch: RTL and testbench

Issue-stage operand collector that drives the read ports of the register file. It accepts decoded instructions over a valid/ready handshake and reads rs/rt through regfile ports 1/2. A 32-entry pending-write scoreboard, plus forwarding from EX and MEM, resolves hazards. Registered operands go to the EX stage over a second valid/ready handshake.

---
 rtl/operand_fetch_pkg.sv | 30 +++
 rtl/operand_fetch_if.sv | 37 +++
 rtl/operand_fetch_op_resolve.sv | 40 ++++
 rtl/operand_fetch.sv | 123 ++++++++++++
 tb/tb_operand_fetch.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths, constants and forwarding-bus type for the operand fetch block.
// No logic of its own; imported by every file in this slice.
// Constants follow the codebase defines: active-high enables and reset.
package operand_fetch_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    localparam logic [DW-1:0] ZeroWord    = '0;
    localparam logic          ReadEnable  = 1'b1;
    localparam logic          WriteEnable = 1'b1;
    localparam logic          RstEnable   = 1'b1;
    localparam logic [15:0]   StallMax    = 16'hFFFF;

    // One pipeline stage's result bus as seen from issue.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          dvalid;
    } fwd_t;

    // True when a stage is writing register r this cycle.
    function automatic logic addr_hit(input logic we, input logic [AW-1:0] waddr,
                                      input logic [AW-1:0] r);
        return (we == WriteEnable) && (waddr == r);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue-side and EX-side valid/ready buses of the operand fetch block.
// master = the stage driving instructions in and consuming operands out.
// slave  = operand_fetch itself.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs;
    logic [AW-1:0] in_rt;
    logic [AW-1:0] in_rd;
    logic          in_use_rs;
    logic          in_use_rt;
    logic          in_wreg;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_op1;
    logic [DW-1:0] out_op2;
    logic [AW-1:0] out_rd;
    logic          out_wreg;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_use_rs, in_use_rt, in_wreg,
        input  in_ready,
        input  out_valid, out_op1, out_op2, out_rd, out_wreg,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_use_rs, in_use_rt, in_wreg,
        output in_ready,
        output out_valid, out_op1, out_op2, out_rd, out_wreg,
        input  out_ready
    );

endinterface

// File: rtl/operand_fetch_op_resolve.sv
// Resolves one source operand from regfile data or EX/MEM/WB forwarding.
// Purely combinational; flags hazard when the producer's value is not visible.
// Caller uses hazard to withhold in_ready.
module op_resolve
    import operand_fetch_pkg::*;
(
    input  logic [AW-1:0] src,
    input  logic          src_used,
    input  logic          pend_bit,
    input  fwd_t          ex,
    input  fwd_t          mem,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] operand,
    output logic          hazard
);

    // Youngest visible producer wins; the regfile already bypasses WB data.
    always_comb begin
        operand = ZeroWord;
        hazard  = 1'b0;
        if (src_used) begin
            if (src == '0 || !pend_bit) begin
                operand = rdata;
            end else if (addr_hit(ex.we, ex.waddr, src)) begin
                if (ex.dvalid) operand = ex.wdata;
                else           hazard  = 1'b1;
            end else if (addr_hit(mem.we, mem.waddr, src)) begin
                if (mem.dvalid) operand = mem.wdata;
                else            hazard  = 1'b1;
            end else if (addr_hit(wb_we, wb_waddr, src)) begin
                operand = rdata;
            end else begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Issue-stage operand collector: regfile read, forwarding, scoreboard, EX handshake.
// Latency 1 cycle (operands registered on fire); throughput 1/cycle without hazards.
// in_ready drops on RAW/WAW hazard or when the output register is full and EX stalls.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    operand_fetch_if.slave    bus,
    output logic [AW-1:0]     raddr1,
    output logic [AW-1:0]     raddr2,
    output logic              re1,
    output logic              re2,
    input  logic [DW-1:0]     rdata1,
    input  logic [DW-1:0]     rdata2,
    input  logic              ex_we,
    input  logic [AW-1:0]     ex_waddr,
    input  logic [DW-1:0]     ex_wdata,
    input  logic              ex_dvalid,
    input  logic              mem_we,
    input  logic [AW-1:0]     mem_waddr,
    input  logic [DW-1:0]     mem_wdata,
    input  logic              mem_dvalid,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_waddr,
    output logic [15:0]       stall_cnt
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    fwd_t            ex_bus;
    fwd_t            mem_bus;
    logic [DW-1:0]   op1;
    logic [DW-1:0]   op2;
    logic            haz1;
    logic            haz2;
    logic            waw;
    logic            fire;

    assign ex_bus  = '{we: ex_we, waddr: ex_waddr, wdata: ex_wdata, dvalid: ex_dvalid};
    assign mem_bus = '{we: mem_we, waddr: mem_waddr, wdata: mem_wdata, dvalid: mem_dvalid};

    assign raddr1 = bus.in_rs;
    assign raddr2 = bus.in_rt;
    assign re1    = bus.in_valid & bus.in_use_rs & ReadEnable;
    assign re2    = bus.in_valid & bus.in_use_rt & ReadEnable;

    op_resolve u_rs (
        .src      (bus.in_rs),
        .src_used (bus.in_use_rs),
        .pend_bit (pend[bus.in_rs]),
        .ex       (ex_bus),
        .mem      (mem_bus),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .rdata    (rdata1),
        .operand  (op1),
        .hazard   (haz1)
    );

    op_resolve u_rt (
        .src      (bus.in_rt),
        .src_used (bus.in_use_rt),
        .pend_bit (pend[bus.in_rt]),
        .ex       (ex_bus),
        .mem      (mem_bus),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .rdata    (rdata2),
        .operand  (op2),
        .hazard   (haz2)
    );

    // A second write to a pending rd must wait unless WB retires it this cycle.
    assign waw = bus.in_wreg & (bus.in_rd != '0) & pend[bus.in_rd]
               & ~addr_hit(wb_we, wb_waddr, bus.in_rd);

    assign bus.in_ready = ~(haz1 | haz2 | waw) & (~bus.out_valid | bus.out_ready);
    assign fire         = bus.in_valid & bus.in_ready;

    // Output register: load on fire, drain on out_ready, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            bus.out_valid <= 1'b0;
            bus.out_op1   <= ZeroWord;
            bus.out_op2   <= ZeroWord;
            bus.out_rd    <= '0;
            bus.out_wreg  <= 1'b0;
        end else if (fire) begin
            bus.out_valid <= 1'b1;
            bus.out_op1   <= op1;
            bus.out_op2   <= op2;
            bus.out_rd    <= bus.in_rd;
            bus.out_wreg  <= bus.in_wreg;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Scoreboard next state: WB clears first, an issuing write then sets (set wins).
    always_comb begin
        pend_nxt = pend;
        if (wb_we == WriteEnable) pend_nxt[wb_waddr] = 1'b0;
        if (fire && bus.in_wreg && bus.in_rd != '0) pend_nxt[bus.in_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) pend <= '0;
        else                  pend <= pend_nxt;
    end

    // Count cycles where upstream offers an instruction we refuse; sticks at max.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt <= '0;
        end else if (bus.in_valid && !bus.in_ready && stall_cnt != StallMax) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
`timescale 1ns/1ps
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_if bus();

    logic [AW-1:0] raddr1, raddr2;
    logic          re1, re2;
    logic [DW-1:0] rdata1, rdata2;
    logic          ex_we, ex_dvalid, mem_we, mem_dvalid, wb_we;
    logic [AW-1:0] ex_waddr, mem_waddr, wb_waddr;
    logic [DW-1:0] ex_wdata, mem_wdata;
    logic [15:0]   stall_cnt;

    logic [DW-1:0] wb_wdata;
    logic [DW-1:0] rf [NREG];

    operand_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .re1        (re1),
        .re2        (re2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .ex_we      (ex_we),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .ex_dvalid  (ex_dvalid),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_dvalid (mem_dvalid),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .stall_cnt  (stall_cnt)
    );

    // Regfile model: combinational read, r0 reads zero, same-cycle WB bypass.
    always_comb begin
        rdata1 = rf[raddr1];
        if (wb_we && wb_waddr == raddr1) rdata1 = wb_wdata;
        if (raddr1 == '0) rdata1 = '0;
        rdata2 = rf[raddr2];
        if (wb_we && wb_waddr == raddr2) rdata2 = wb_wdata;
        if (raddr2 == '0) rdata2 = '0;
    end

    // Reference state
    bit            pend_m [NREG];
    logic          ov_m;
    logic [DW-1:0] op1_m, op2_m;
    logic [AW-1:0] rd_m;
    logic          wreg_m;
    int            stall_m;
    logic          samp_ready;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rf_value(input logic [AW-1:0] s);
        if (s == '0) return '0;
        if (wb_we && wb_waddr == s) return wb_wdata;
        return rf[s];
    endfunction

    // Source value per the hazard rules: walk visible stages youngest-first.
    task automatic resolve(input logic [AW-1:0] s, input logic used,
                           output logic [DW-1:0] val, output logic haz);
        logic          st_we  [3];
        logic [AW-1:0] st_adr [3];
        logic [DW-1:0] st_dat [3];
        logic          st_ok  [3];
        logic          found;
        val = '0;
        haz = 1'b0;
        if (used) begin
            if (s == '0 || !pend_m[s]) begin
                val = rf_value(s);
            end else begin
                st_we  = '{ex_we, mem_we, wb_we};
                st_adr = '{ex_waddr, mem_waddr, wb_waddr};
                st_dat = '{ex_wdata, mem_wdata, wb_wdata};
                st_ok  = '{ex_dvalid, mem_dvalid, 1'b1};
                found  = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (!found && st_we[k] && st_adr[k] == s) begin
                        found = 1'b1;
                        if (st_ok[k]) val = st_dat[k];
                        else          haz = 1'b1;
                    end
                end
                if (!found) haz = 1'b1;
            end
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registers.
    task automatic step();
        logic [DW-1:0] e1, e2;
        logic          h1, h2, waw, er, fire;
        @(negedge clk);
        resolve(bus.in_rs, bus.in_use_rs, e1, h1);
        resolve(bus.in_rt, bus.in_use_rt, e2, h2);
        waw = bus.in_wreg && bus.in_rd != '0 && pend_m[bus.in_rd]
              && !(wb_we && wb_waddr == bus.in_rd);
        er = !(h1 || h2 || waw) && (!ov_m || bus.out_ready);
        samp_ready = bus.in_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("re1", 32'(re1), 32'(bus.in_valid && bus.in_use_rs));
        chk("re2", 32'(re2), 32'(bus.in_valid && bus.in_use_rt));
        chk("raddr1", 32'(raddr1), 32'(bus.in_rs));
        chk("raddr2", 32'(raddr2), 32'(bus.in_rt));
        fire = bus.in_valid && er;
        @(posedge clk);
        if (rst) begin
            foreach (pend_m[i]) pend_m[i] = 1'b0;
            ov_m = 1'b0; op1_m = '0; op2_m = '0; rd_m = '0; wreg_m = 1'b0; stall_m = 0;
        end else begin
            if (fire) begin
                ov_m = 1'b1; op1_m = e1; op2_m = e2; rd_m = bus.in_rd; wreg_m = bus.in_wreg;
            end else if (bus.out_ready) begin
                ov_m = 1'b0;
            end
            if (wb_we) pend_m[wb_waddr] = 1'b0;
            if (fire && bus.in_wreg && bus.in_rd != '0) pend_m[bus.in_rd] = 1'b1;
            if (bus.in_valid && !er && stall_m < 65535) stall_m++;
        end
        if (wb_we && wb_waddr != '0) rf[wb_waddr] = wb_wdata;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(ov_m));
        chk("out_op1", bus.out_op1, op1_m);
        chk("out_op2", bus.out_op2, op2_m);
        chk("out_rd", 32'(bus.out_rd), 32'(rd_m));
        chk("out_wreg", 32'(bus.out_wreg), 32'(wreg_m));
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    endtask

    task automatic instr(input logic v, input int rs, input int rt, input int rd,
                         input logic urs, input logic urt, input logic wreg);
        bus.in_valid  = v;
        bus.in_rs     = AW'(rs);
        bus.in_rt     = AW'(rt);
        bus.in_rd     = AW'(rd);
        bus.in_use_rs = urs;
        bus.in_use_rt = urt;
        bus.in_wreg   = wreg;
    endtask

    task automatic quiet_fwd();
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_dvalid = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_dvalid = 1'b0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    endtask

    initial begin
        foreach (rf[i]) rf[i] = $urandom;
        rf[0] = '0; rf[5] = 32'h11; rf[6] = 32'h22;
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        ov_m = 1'b0; op1_m = '0; op2_m = '0; rd_m = '0; wreg_m = 1'b0; stall_m = 0;
        quiet_fwd();
        instr(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_op1", bus.out_op1, 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);

        // Idle issue, then pending r7 blocks a reader until WB of r7.
        instr(1'b1, 5, 6, 7, 1'b1, 1'b1, 1'b1);
        step();
        chk("idle_op1", bus.out_op1, 32'h11);
        chk("idle_op2", bus.out_op2, 32'h22);
        chk("idle_rd", 32'(bus.out_rd), 32'd7);
        instr(1'b1, 7, 0, 0, 1'b1, 1'b0, 1'b0);
        step();
        chk("pend7_stall", 32'(samp_ready), 32'd0);
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h77;
        step();
        chk("wb_bypass_ready", 32'(samp_ready), 32'd1);
        chk("wb_bypass_op1", bus.out_op1, 32'h77);
        quiet_fwd();

        // EX forward beats MEM on the same register.
        instr(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1);
        step();
        instr(1'b1, 3, 0, 0, 1'b1, 1'b0, 1'b0);
        ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'hDEAD; ex_dvalid = 1'b1;
        mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hBEEF; mem_dvalid = 1'b1;
        step();
        chk("ex_fwd_ready", 32'(samp_ready), 32'd1);
        chk("ex_fwd_op1", bus.out_op1, 32'hDEAD);
        quiet_fwd();

        // Load-use: EX has no data yet, MEM supplies it the next cycle.
        instr(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        instr(1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b1);
        step();
        instr(1'b1, 4, 0, 0, 1'b1, 1'b0, 1'b0);
        ex_we = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'h1234; ex_dvalid = 1'b0;
        step();
        chk("load_use_stall", 32'(samp_ready), 32'd0);
        chk("load_use_cnt", 32'(stall_cnt), 32'd1);
        quiet_fwd();
        mem_we = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h44; mem_dvalid = 1'b1;
        step();
        chk("mem_fwd_ready", 32'(samp_ready), 32'd1);
        chk("mem_fwd_op1", bus.out_op1, 32'h44);
        quiet_fwd();

        // WAW on r8: waits for WB of r8, fires that cycle, r8 stays pending.
        instr(1'b1, 0, 0, 8, 1'b0, 1'b0, 1'b1);
        step();
        step();
        chk("waw_stall_a", 32'(samp_ready), 32'd0);
        step();
        chk("waw_stall_b", 32'(samp_ready), 32'd0);
        wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'h88;
        step();
        chk("waw_fire", 32'(samp_ready), 32'd1);
        quiet_fwd();
        instr(1'b1, 8, 0, 0, 1'b1, 1'b0, 1'b0);
        step();
        chk("waw_pend_kept", 32'(samp_ready), 32'd0);

        // Backpressure: output holds for 3 cycles, then next instruction accepted.
        instr(1'b1, 5, 6, 0, 1'b1, 1'b1, 1'b0);
        step();
        bus.out_ready = 1'b0;
        instr(1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 32'(samp_ready), 32'd0);
            chk("bp_hold_op1", bus.out_op1, 32'h11);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", 32'(samp_ready), 32'd1);
        chk("bp_new_op1", bus.out_op1, rf[1]);

        // r0 source and r0 destination never hazard.
        instr(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        step();
        chk("r0_ready", 32'(samp_ready), 32'd1);
        chk("r0_op1", bus.out_op1, 32'd0);
        step();
        chk("r0_no_waw", 32'(samp_ready), 32'd1);

        // Reset with pending registers and a full output stage.
        bus.out_ready = 1'b0;
        instr(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_op1", bus.out_op1, 32'd0);
        bus.out_ready = 1'b1;
        instr(1'b1, 8, 4, 8, 1'b1, 1'b1, 1'b1);
        step();
        chk("rst_pend_clear", 32'(samp_ready), 32'd1);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            instr(rst ? 1'b0 : ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
                  ($urandom_range(0, 2) != 0));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            ex_we      = ($urandom_range(0, 1) != 0);
            ex_waddr   = AW'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_dvalid  = ($urandom_range(0, 2) != 0);
            mem_we     = ($urandom_range(0, 1) != 0);
            mem_waddr  = AW'($urandom_range(0, 7));
            mem_wdata  = $urandom;
            mem_dvalid = ($urandom_range(0, 2) != 0);
            wb_we      = ($urandom_range(0, 1) != 0);
            wb_waddr   = AW'($urandom_range(0, 7));
            wb_wdata   = $urandom;
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
